gaussian_window_filter: RTL and testbench

Parametrised KSIZE x KSIZE binomial (Gaussian) filter over a raster pixel stream, for KSIZE = 3 or 5. Next generation of the fixed 5x5 window block.
- Internally: KSIZE-1 line buffers plus a KSIZE x KSIZE register window.
- Emits one filtered pixel per accepted input pixel, at a fixed latency.
- Sits between the camera/pixel source and the feature-detection stages.
- Border pixels are forced to a defined value.

---
 rtl/gaussian_window_filter.sv | 179 +++++++++++++++++
 tb/tb_gaussian_window_filter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_window_filter.sv
// KSIZE x KSIZE binomial filter over a raster pixel stream, 3-cycle latency.
// Macro GAUSSIAN_BORDER_PASSTHROUGH_EN: border outputs the raw centre pixel.
module gaussian_window_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 210,
  parameter int KSIZE      = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  validin,
  input  logic                  blanking_in,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid_out,
  output logic                  blanking_out
);
  localparam int R  = (KSIZE - 1) / 2;
  localparam int SH = 2 * (KSIZE - 1);
  localparam int AW = DATA_WIDTH + SH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [AW-1:0] RND = AW'(1) << (SH - 1);

  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("gaussian_window_filter: KSIZE must be 3 or 5");
  end

  function automatic int coef(input int i);
    if (KSIZE == 3) return (i == 1) ? 2 : 1;
    if (i == 2) return 6;
    if (i == 1 || i == 3) return 4;
    return 1;
  endfunction

  function automatic logic [AW-1:0] wmul(
    input logic [AW-1:0] x,
    input int            i
  );
    case (coef(i))
      2:       return x << 1;
      4:       return x << 2;
      6:       return (x << 2) + (x << 1);
      default: return x;
    endcase
  endfunction

  logic [CW-1:0]         r_col;
  logic [CW-1:0]         w_col_nx;
  logic [RW-1:0]         r_row;
  logic                  w_acc;
  logic                  w_eol;
  logic                  w_bd;
  logic [DATA_WIDTH-1:0] r_lb [KSIZE-1][WIDTH];
  logic [DATA_WIDTH-1:0] r_rd [KSIZE-1];
  logic [DATA_WIDTH-1:0] w_colv [KSIZE];
  logic [DATA_WIDTH-1:0] r_win [KSIZE][KSIZE];
  logic [AW-1:0]         w_h [KSIZE];
  logic [AW-1:0]         r_h [KSIZE];
  logic [AW-1:0]         w_vs;
  logic                  r_v1, r_v2, r_v3;
  logic                  r_b1, r_b2, r_b3;
  logic                  r_bd1, r_bd2;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] w_bval;

  assign w_acc = validin & ~reset;
  assign w_eol = (r_col == CW'(WIDTH - 1));
  // Centre lags by R lines + R pixels, so only the counters are needed.
  assign w_bd  = (r_col < CW'(2 * R)) || (r_row < RW'(2 * R));

  // Next column address, used to prefetch line-buffer data
  always_comb begin
    w_col_nx = r_col;
    if (reset)
      w_col_nx = '0;
    else if (validin)
      w_col_nx = w_eol ? '0 : r_col + CW'(1);
  end

  // Column and row counters, framing purely by count
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (validin) begin
      r_col <= w_col_nx;
      if (w_eol)
        r_row <= (r_row == RW'(HEIGHT - 1)) ? '0 : r_row + RW'(1);
    end
  end

  // New window column: current pixel plus one pixel from each older line
  always_comb begin
    w_colv[0] = din;
    for (int k = 1; k < KSIZE; k++)
      w_colv[k] = r_rd[k-1];
  end

  // Line-buffer cascade, each RAM a one-line delay of the one above
  always_ff @(posedge clock) begin
    for (int k = 0; k < KSIZE - 1; k++) begin
      r_rd[k] <= r_lb[k][w_col_nx];
      if (w_acc)
        r_lb[k][r_col] <= w_colv[k];
    end
  end

  // Stage 1: shift the window on every accepted pixel
  always_ff @(posedge clock) begin
    if (w_acc) begin
      r_bd1 <= w_bd;
      for (int i = 0; i < KSIZE; i++) begin
        r_win[i][0] <= w_colv[i];
        for (int j = 1; j < KSIZE; j++)
          r_win[i][j] <= r_win[i][j-1];
      end
    end
  end

  // Horizontal weighted sum of each window row
  always_comb begin
    for (int i = 0; i < KSIZE; i++) begin
      w_h[i] = '0;
      for (int j = 0; j < KSIZE; j++)
        w_h[i] = w_h[i] + wmul(AW'(r_win[i][j]), j);
    end
  end

  // Stage 2: register row sums and border flag
  always_ff @(posedge clock) begin
    r_h   <= w_h;
    r_bd2 <= r_bd1;
  end

`ifdef GAUSSIAN_BORDER_PASSTHROUGH_EN
  logic [DATA_WIDTH-1:0] r_ctr2;
  // Raw centre pixel travels alongside the row sums
  always_ff @(posedge clock) begin
    r_ctr2 <= r_win[R][R];
  end
  assign w_bval = r_ctr2;
`else
  assign w_bval = '0;
`endif

  // Vertical weighted sum with round-half-up bias
  always_comb begin
    w_vs = RND;
    for (int i = 0; i < KSIZE; i++)
      w_vs = w_vs + wmul(r_h[i], i);
  end

  // Stage 3: normalise, border select, and control pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_b1   <= 1'b0;
      r_b2   <= 1'b0;
      r_b3   <= 1'b0;
      r_dout <= '0;
    end else begin
      r_v1 <= validin;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_b1 <= blanking_in;
      r_b2 <= r_b1;
      r_b3 <= r_b2;
      if (r_v2)
        r_dout <= r_bd2 ? w_bval : DATA_WIDTH'(w_vs >> SH);
    end
  end

  assign dout         = r_dout;
  assign valid_out    = r_v3;
  assign blanking_out = r_b3;
endmodule

// File: tb/tb_gaussian_window_filter.sv
// Self-checking bench for gaussian_window_filter, KSIZE 3 and 5 in parallel.
// Raster-index reference model; table checks for the impulse response.
module tb_gaussian_window_filter;
  localparam int DW   = 8;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int WH   = W * H;
  localparam int NMAX = 8192;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] din = '0;
  logic          validin = 1'b0;
  logic          blanking_in = 1'b0;
  logic [DW-1:0] dout5, dout3;
  logic          valid5, valid3;
  logic          blank5, blank3;

  typedef struct {
    bit v; bit b; bit c3; bit c5;
    int e3; int e5; int p3; int p5;
  } rec_t;

  typedef struct {
    int k; int row; int col; int exp;
  } imp_t;

  rec_t recs [NMAX];
  int   hist [NMAX];
  bit   bo [NMAX];
  bit   vo [NMAX];
  int   cap3 [WH];
  int   cap5 [WH];
  imp_t imp [10];
  int   nacc, nstep;
  int   checks, errors;
  int   vin_cnt, vout_cnt;
  bit   cap_en;

  always #5 clock = ~clock;

  gaussian_window_filter #(
    .DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .KSIZE(5)
  ) u_k5 (
    .clock(clock), .reset(reset), .din(din),
    .validin(validin), .blanking_in(blanking_in),
    .dout(dout5), .valid_out(valid5), .blanking_out(blank5)
  );

  gaussian_window_filter #(
    .DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .KSIZE(3)
  ) u_k3 (
    .clock(clock), .reset(reset), .din(din),
    .validin(validin), .blanking_in(blanking_in),
    .dout(dout3), .valid_out(valid3), .blanking_out(blank3)
  );

  // Expected output for the n-th pixel accepted since reset.
  function automatic void model(input int n, input int k,
                                output bit chk, output int e,
                                output int cpos);
    int r, p, q, cr, cc, m, s, sh;
    int cf [5];
    r = (k - 1) / 2;
    if (k == 3) cf = '{1, 2, 1, 0, 0};
    else        cf = '{1, 4, 6, 4, 1};
    p  = n % WH;
    q  = (p - (r * W + r) + WH) % WH;
    cr = q / W;
    cc = q % W;
    m  = n - (r * W + r);
    cpos = q;
    chk  = 1'b1;
    e    = 0;
    if (cr < r || cr >= H - r || cc < r || cc >= W - r) begin
`ifdef GAUSSIAN_BORDER_PASSTHROUGH_EN
      if (m < 0) chk = 1'b0;
      else       e = hist[m];
`else
      e = 0;
`endif
    end else begin
      s = 0;
      for (int di = 0; di < k; di++)
        for (int dj = 0; dj < k; dj++)
          s += cf[di] * cf[dj] * hist[m + (di - r) * W + (dj - r)];
      sh = 2 * (k - 1);
      e  = (s + (1 << (sh - 1))) >> sh;
    end
  endfunction

  task automatic check_out(input int k);
    rec_t rc;
    rc = recs[k];
    checks++;
    if (valid5 !== rc.v || valid3 !== rc.v) begin
      errors++;
      $display("FAIL valid step %0d: got k5=%b k3=%b want %b",
               k, valid5, valid3, rc.v);
    end
    checks++;
    if (blank5 !== rc.b || blank3 !== rc.b) begin
      errors++;
      $display("FAIL blanking step %0d: got k5=%b k3=%b want %b",
               k, blank5, blank3, rc.b);
    end
    if (valid5 === 1'b1) vout_cnt++;
    if (rc.v) begin
      if (rc.c5) begin
        checks++;
        if (dout5 !== DW'(rc.e5)) begin
          errors++;
          $display("FAIL dout_k5 step %0d pos %0d: got %0d want %0d",
                   k, rc.p5, dout5, rc.e5);
        end
      end
      if (rc.c3) begin
        checks++;
        if (dout3 !== DW'(rc.e3)) begin
          errors++;
          $display("FAIL dout_k3 step %0d pos %0d: got %0d want %0d",
                   k, rc.p3, dout3, rc.e3);
        end
      end
      if (cap_en) begin
        cap5[rc.p5] = int'(dout5);
        cap3[rc.p3] = int'(dout3);
      end
    end
  endtask

  task automatic step(input bit rst, input bit v,
                      input int d, input bit b);
    rec_t rc;
    reset       = rst;
    validin     = v;
    din         = DW'(d);
    blanking_in = b;
    rc.v  = v && !rst;
    rc.b  = b && !rst;
    rc.c3 = 1'b0; rc.c5 = 1'b0;
    rc.e3 = 0;    rc.e5 = 0;
    rc.p3 = 0;    rc.p5 = 0;
    if (rst) begin
      nacc = 0;
      if (nstep >= 1) begin
        recs[nstep-1].v = 1'b0;
        recs[nstep-1].b = 1'b0;
      end
      if (nstep >= 2) begin
        recs[nstep-2].v = 1'b0;
        recs[nstep-2].b = 1'b0;
      end
    end else if (v) begin
      hist[nacc] = d & 255;
      model(nacc, 3, rc.c3, rc.e3, rc.p3);
      model(nacc, 5, rc.c5, rc.e5, rc.p5);
      nacc++;
      vin_cnt++;
    end
    recs[nstep] = rc;
    @(posedge clock);
    #1;
    bo[nstep] = blank5;
    vo[nstep] = valid5;
    if (nstep >= 2) check_out(nstep - 2);
    nstep++;
  endtask

  task automatic idle(input int n, input bit rb);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 0, rb ? bit'($urandom_range(0, 1)) : 1'b0);
  endtask

  task automatic frame_flat(input int val);
    for (int i = 0; i < WH; i++) step(1'b0, 1'b1, val, 1'b0);
  endtask

  task automatic cnt_check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    int j, gap;
    checks = 0; errors = 0; nacc = 0; nstep = 0;
    vin_cnt = 0; vout_cnt = 0; cap_en = 1'b0;
    imp[0] = '{3, 2, 3, 64};
    imp[1] = '{3, 1, 3, 32};
    imp[2] = '{3, 2, 2, 32};
    imp[3] = '{3, 1, 2, 16};
    imp[4] = '{3, 4, 3, 0};
    imp[5] = '{5, 2, 3, 36};
    imp[6] = '{5, 2, 4, 24};
    imp[7] = '{5, 3, 3, 24};
    imp[8] = '{5, 3, 4, 16};
    imp[9] = '{5, 2, 5, 6};

    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 77, 1'b1);
    cnt_check("reset_dout_k5", int'(dout5), 0);
    cnt_check("reset_dout_k3", int'(dout3), 0);
    cnt_check("reset_valid", int'(valid5) + int'(valid3), 0);
    cnt_check("reset_blank", int'(blank5) + int'(blank3), 0);

    vin_cnt = 0; vout_cnt = 0;
    frame_flat(100);
    frame_flat(100);
    idle(4, 1'b0);
    cnt_check("flat_valid_pulses", vout_cnt, 96);

    frame_flat(1);
    frame_flat(255);
    idle(3, 1'b0);

    for (int i = 0; i < WH; i++) begin
      cap3[i] = -1;
      cap5[i] = -1;
    end
    cap_en = 1'b1;
    for (int i = 0; i < WH; i++)
      step(1'b0, 1'b1, (i == 2 * W + 3) ? 255 : 0, 1'b0);
    idle(3, 1'b0);
    cap_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      j = imp[i].row * W + imp[i].col;
      checks++;
      if ((imp[i].k == 3 ? cap3[j] : cap5[j]) != imp[i].exp) begin
        errors++;
        $display("FAIL impulse k%0d (%0d,%0d): got %0d want %0d",
                 imp[i].k, imp[i].row, imp[i].col,
                 imp[i].k == 3 ? cap3[j] : cap5[j], imp[i].exp);
      end
    end

    vin_cnt = 0; vout_cnt = 0;
    for (int i = 0; i < WH; i++) begin
      step(1'b0, 1'b1, int'($urandom_range(0, 255)),
           bit'($urandom_range(0, 1)));
      if (i % 2 == 0) idle(2, 1'b1);
      if (i == 20) idle(20, 1'b1);
    end
    idle(4, 1'b0);
    cnt_check("stall_valid_count", vout_cnt, vin_cnt);

    vout_cnt = 0;
    j = nstep;
    step(1'b0, 1'b0, 0, 1'b1);
    idle(5, 1'b0);
    cnt_check("blank_at_n2", int'(bo[j+1]), 0);
    cnt_check("blank_at_n3", int'(bo[j+2]), 1);
    cnt_check("blank_at_n4", int'(bo[j+3]), 0);
    cnt_check("blank_no_valid", vout_cnt, 0);

    for (int i = 0; i < 27; i++) step(1'b0, 1'b1, i + 50, 1'b0);
    j = nstep;
    step(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < WH; i++) step(1'b0, 1'b1, i, 1'b0);
    for (int i = 0; i < WH; i++)
      step(1'b0, 1'b1, int'($urandom_range(0, 255)), 1'b0);
    idle(4, 1'b0);
    cnt_check("rst_valid_c1", int'(vo[j]), 0);
    cnt_check("rst_valid_c2", int'(vo[j+1]), 0);
    cnt_check("rst_valid_c3", int'(vo[j+2]), 0);
    cnt_check("rst_first_out", int'(vo[j+3]), 1);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < WH; i++) begin
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        idle(gap, 1'b1);
        step(1'b0, 1'b1, int'($urandom_range(0, 255)),
             bit'($urandom_range(0, 1)));
      end
    end
    idle(4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
